// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter
// Round-robin Wishbone arbiter. It shares one Wishbone master port (s_*)
// between N requesting masters (m_*). Once a master wins, the grant is held
// for its whole bus cycle (m_cyc high). Priority rotates to the index after
// the previous owner. If the owner stalls for TIMEOUT consecutive cycles,
// its cycle is aborted with a one-cycle m_err pulse.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we [N]   : requester cycle, strobe and write-enable
//   m_adr/m_sel/m_dat_ms   : requester address, byte selects and write data
//                            (packed; master i occupies slice i)
//   m_cti/m_bte            : requester burst tags (packed)
//   m_ack [N]              : s_ack routed to the current owner only
//   m_err [N]              : one-cycle timeout abort pulse to the owner
//   m_dat_sm               : read data, broadcast to all masters
//   s_*                    : shared port; all zero while nothing is granted
//   s_ack, s_dat_sm        : shared port ack and read data
//   gnt [N]                : registered one-hot grant, or all zero
//   busy                   : high whenever the arbiter is not idle
module wshb_rr_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      m_cyc,
  input  logic [N-1:0]      m_stb,
  input  logic [N-1:0]      m_we,
  input  logic [N*AW-1:0]   m_adr,
  input  logic [N*DW/8-1:0] m_sel,
  input  logic [N*DW-1:0]   m_dat_ms,
  input  logic [N*3-1:0]    m_cti,
  input  logic [N*2-1:0]    m_bte,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_err,
  output logic [DW-1:0]     m_dat_sm,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [AW-1:0]     s_adr,
  output logic [DW/8-1:0]   s_sel,
  output logic [DW-1:0]     s_dat_ms,
  output logic [2:0]        s_cti,
  output logic [1:0]        s_bte,
  input  logic              s_ack,
  input  logic [DW-1:0]     s_dat_sm,
  output logic [N-1:0]      gnt,
  output logic              busy
);

  localparam int unsigned PW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned SW   = DW / 8;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [N-1:0]   m_err_q, m_err_d;

  logic [PW-1:0]  own_idx;
  logic [PW-1:0]  next_ptr;
  logic           own_cyc;
  logic           own_stb;
  logic           stalled;
  logic [N-1:0]   handover;

  function automatic logic [N-1:0] first_one(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i] && (r == '0)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Lowest requester at or above start, otherwise wrap to the lowest overall:
  // equivalent to scanning start, start+1, ... modulo N.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                           input logic [PW-1:0] start);
    logic [N-1:0] upper;
    upper = '0;
    for (int unsigned i = 0; i < N; i++) begin
      upper[i] = req[i] && (i >= 32'(start));
    end
    return (upper != '0) ? first_one(upper) : first_one(req);
  endfunction

  always_comb begin
    own_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) own_idx = PW'(i);
    end
  end

  assign next_ptr = (own_idx == PW'(N - 1)) ? '0 : own_idx + PW'(1);
  assign own_cyc  = |(m_cyc & gnt_q);
  assign own_stb  = |(m_stb & gnt_q);
  assign stalled  = s_stb && !s_ack;
  // Back-to-back hand-over: the releasing owner is excluded and comes last.
  assign handover = rr_pick(m_cyc & ~gnt_q, next_ptr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      m_err_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      m_err_q <= m_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    tcnt_d  = '0;
    m_err_d = '0;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc) begin
          gnt_d   = rr_pick(m_cyc, ptr_q);
          state_d = OWN;
        end
      end
      OWN: begin
        if (!own_cyc) begin
          ptr_d = next_ptr;
          gnt_d = handover;
          if (handover == '0) state_d = IDLE;
        end else if (stalled) begin
          if ((TIMEOUT != 0) && (32'(tcnt_q) == TLIM)) begin
            m_err_d = gnt_q;
            state_d = ABORT;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          ptr_d   = next_ptr;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    s_cyc    = (state_q == OWN) && own_cyc;
    s_stb    = (state_q == OWN) && own_cyc && own_stb;
    m_ack    = (state_q == OWN) ? (gnt_q & {N{s_ack}}) : '0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    s_cti    = '0;
    s_bte    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s_we     = s_we     | (m_we[i] & gnt_q[i]);
      s_adr    = s_adr    | (m_adr[i*AW +: AW]    & {AW{gnt_q[i]}});
      s_sel    = s_sel    | (m_sel[i*SW +: SW]    & {SW{gnt_q[i]}});
      s_dat_ms = s_dat_ms | (m_dat_ms[i*DW +: DW] & {DW{gnt_q[i]}});
      s_cti    = s_cti    | (m_cti[i*3 +: 3]      & {3{gnt_q[i]}});
      s_bte    = s_bte    | (m_bte[i*2 +: 2]      & {2{gnt_q[i]}});
    end
  end

  assign m_dat_sm = s_dat_sm;
  assign m_err    = m_err_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/wshb_rr_arbiter.md
# wshb_rr_arbiter

Round-robin Wishbone arbiter that shares one Wishbone master port, the SDRAM/bridge side, between N requesting masters such as the pattern generator and the VGA reader. It locks the grant for the whole bus cycle (`cyc` held high), rotates priority fairly between cycles, and aborts a stalled cycle with `err` after a programmable number of wait cycles. It replaces fixed token toggling with demand-driven arbitration.

## Interface
Parameters:
- `N`, 2: number of requesting masters, 2..8.
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` is `DW/8` bits.
- `TIMEOUT`, 255: maximum consecutive stalled cycles (`stb` high, `ack` low) before abort. 0 disables the timeout.

Ports. Per-master buses are packed, and master i occupies slice i.
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `m_cyc`, `m_stb`, `m_we`, in, N each: requester cycle, strobe and write-enable.
- `m_adr`, in, N*AW: requester addresses.
- `m_sel`, in, N*DW/8: requester byte selects.
- `m_dat_ms`, in, N*DW: requester write data.
- `m_cti`, in, N*3; `m_bte`, in, N*2: requester burst tags.
- `m_ack`, out, N: ack, routed to the owner only.
- `m_err`, out, N: one-cycle timeout abort pulse to the owner.
- `m_dat_sm`, out, DW: read data, broadcast to all masters.
- `s_cyc`, `s_stb`, `s_we`, out, 1 each: shared port controls.
- `s_adr`, out, AW; `s_sel`, out, DW/8; `s_dat_ms`, out, DW; `s_cti`, out, 3; `s_bte`, out, 2: shared port address, selects, data and burst tags.
- `s_ack`, in, 1: shared port ack.
- `s_dat_sm`, in, DW: shared port read data.
- `gnt`, out, N: registered one-hot grant, or all zero.
- `busy`, out, 1: high when the state is not IDLE.

## Operation
- Registered state: `state` (IDLE, OWN, ABORT), `gnt`, `ptr` (log2 N bits, the priority start index), `tcnt` (stall counter), and `m_err`.
- Winner selection: the first index i with `m_cyc[i]=1`, searching `ptr`, `ptr+1`, … modulo N.
- IDLE:
  - Shared port controls are 0.
  - If any `m_cyc` is high, register `gnt`=onehot(winner) and go to OWN.
- OWN:
  - The shared port is a combinational mux of the granted master, with `s_cyc = m_cyc[own] & gnt[own]` and `s_stb` likewise.
  - `m_ack[own]=s_ack`; all other `m_ack` are 0.
- Release, in OWN when `m_cyc[own]=0` on an edge:
  - `ptr` <= own+1 mod N.
  - If another master is requesting, `gnt` <= winner computed with the new `ptr`, excluding `own`, and the state stays OWN.
  - Otherwise `gnt`<=0 and the state goes to IDLE.
- Grant stability: a request that arrives while `m_cyc[own]` is high never changes `gnt`.
- Stall counter:
  - `tcnt` increments each OWN cycle with `s_stb=1` and `s_ack=0`.
  - It clears on `s_ack=1`, on `s_stb=0`, and on any grant change.
- Timeout (`TIMEOUT`≠0 and `tcnt`==`TIMEOUT-1` while stalled):
  - `m_err[own]` <= 1 for one cycle.
  - `gnt` is held, the state goes to ABORT, and `tcnt` <= 0.
- ABORT:
  - `s_cyc`, `s_stb` and all `m_ack` are 0.
  - When `m_cyc[own]=0`: `ptr` <= own+1, `gnt` <= 0, and the state goes to IDLE.
  - ABORT never grants directly.
- Zero values: with `gnt`=0, every `s_*` output is 0.
- Reset (`rst_n`=0, immediate):
  - `state`=IDLE, `gnt`=0, `ptr`=0, `tcnt`=0.
  - All `m_ack`, `m_err`, `s_cyc`, `s_stb`, `s_we`, `s_adr`, `s_sel`, `s_dat_ms`, `s_cti`, `s_bte` are 0, and `busy`=0.
  - Reset mid-cycle drops `s_cyc` asynchronously, and no ack is forwarded afterward.

## Timing
- Grant latency: `m_cyc[i]` high at edge k (state IDLE) gives `gnt[i]` and `s_cyc` high after edge k+1. That is one cycle.
- Hand-over: the owner drops `m_cyc` in cycle c, `s_cyc`=0 in cycle c (combinational), and the next owner drives the port from cycle c+1. There is exactly one dead cycle.
- Ack paths: `s_ack` to `m_ack[own]` and `s_dat_sm` to `m_dat_sm` are purely combinational, with zero latency.
- Abort timing: the abort asserts at the edge after the `TIMEOUT`-th stalled cycle. `m_err` is high for exactly one cycle.
- Simultaneous events:
  - If `s_ack` arrives in the same cycle `tcnt` reaches its limit, the ack wins: no abort, and `tcnt` clears.
  - If all N request at once, grants go in order `ptr`, `ptr+1`, …, and every requester is served within N cycles of ownership.

## Test plan
- Reset, then `m_cyc[0]` high at edge 2: `gnt`=01 and `s_cyc`=1 after edge 3. `s_adr` equals `m_adr[0]`, and `m_ack[1]` stays 0.
- N=2, both masters hold `cyc` continuously with 4-beat bursts, each dropping `cyc` for 1 cycle after its 4th ack: grants alternate 0,1,0,1 with one `s_cyc`=0 cycle between owners.
- Master 1 raises `cyc` mid-way through master 0's burst: `gnt` stays 01 until `m_cyc[0]` falls. Then `gnt`=10 the next cycle.
- TIMEOUT=4, owner 0 stalls with `stb`=1 and no `s_ack`: `m_err[0]` pulses after the 4th stalled cycle and `s_cyc`=0. Master 1 is granted only after `m_cyc[0]` drops.
- `s_ack` arrives on the 4th stalled cycle with TIMEOUT=4: normal ack is forwarded and `m_err` stays 0.
- `rst_n` pulled low during master 1's burst: `s_cyc`, `gnt` and `ptr` go to 0 immediately. After release, master 0 wins a simultaneous request.
